s526_bist_wrap: RTL

//  Self-test harness stage wrapped around the s526 sequential netlist. Upstream side: drives
//  CUT inputs G0/G1/G2, with G0 used as a synchronous clear and G1/G2 taken from a pseudo-random LFSR.

---
 rtl/s526_bist_wrap.sv | 132 +++++++++++++
 1 files changed

// File: rtl/s526_bist_wrap.sv
// rtl/s526_bist_wrap.sv - BIST harness around s526: LFSR stimulus, MISR compaction, PASS flag
module s526_bist_wrap #(
    parameter int          NCYC     = 64,
    parameter int          INIT_CYC = 2,
    parameter logic [7:0]  SEED     = 8'hA5
) (
    input  logic        CK,
    input  logic        RN,
    input  logic        START,
    input  logic [15:0] EXP_SIG,
    input  logic [5:0]  CUT_Q,
    output logic        G0_O,
    output logic        G1_O,
    output logic        G2_O,
    output logic        BUSY,
    output logic        DONE,
    output logic [15:0] SIG,
    output logic        PASS
);

    // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
    localparam logic [7:0] SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;
    // The counter has to hold both load values; with the defaults this is 7 bits.
    localparam int CMAX = (NCYC > INIT_CYC) ? NCYC : INIT_CYC;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] INIT_LOAD = CW'(INIT_CYC - 1);
    localparam logic [CW-1:0] RUN_LOAD  = CW'(NCYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          state;
    logic [7:0]      lfsr;
    logic [CW-1:0]   cnt;
    logic [7:0]      lfsr_next;
    logic [15:0]     sig_next;

    // Next LFSR value (x^8+x^6+x^5+x^4+1, shift toward MSB).
    always_comb begin
        lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    // Next MISR value: Galois step with poly 0x1021, then fold in the CUT response.
    always_comb begin
        sig_next = ({SIG[14:0], 1'b0} ^ (SIG[15] ? 16'h1021 : 16'h0000)) ^ {10'b0, CUT_Q};
    end

    // Session FSM with all CUT drives and status outputs registered.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state <= S_IDLE;
            G0_O  <= 1'b1;
            G1_O  <= 1'b0;
            G2_O  <= 1'b0;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
            SIG   <= 16'h0000;
            PASS  <= 1'b0;
            lfsr  <= SEED_EFF;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    // PASS tracks EXP_SIG continuously while the signature is frozen.
                    if (state == S_DONE) begin
                        PASS <= (SIG == EXP_SIG);
                    end
                    if (START) begin
                        state <= S_INIT;
                        cnt   <= INIT_LOAD;
                        BUSY  <= 1'b1;
                        DONE  <= 1'b0;
                        PASS  <= 1'b0;
                        SIG   <= 16'h0000;
                        lfsr  <= SEED_EFF;
                        G0_O  <= 1'b1;
                        G1_O  <= 1'b0;
                        G2_O  <= 1'b0;
                    end
                end
                S_INIT: begin
                    SIG <= 16'h0000;
                    if (cnt == '0) begin
                        // First stimulus comes straight from the seed.
                        state <= S_RUN;
                        cnt   <= RUN_LOAD;
                        G0_O  <= 1'b0;
                        G1_O  <= lfsr[0];
                        G2_O  <= lfsr[1];
                        lfsr  <= lfsr_next;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_RUN: begin
                    // The CUT is one flop deep, so the first RUN cycle has no response yet.
                    if (cnt != RUN_LOAD) begin
                        SIG <= sig_next;
                    end
                    if (cnt == '0) begin
                        state <= S_DRAIN;
                        G0_O  <= 1'b1;
                        G1_O  <= 1'b0;
                        G2_O  <= 1'b0;
                    end else begin
                        cnt  <= cnt - 1'b1;
                        G1_O <= lfsr[0];
                        G2_O <= lfsr[1];
                        lfsr <= lfsr_next;
                    end
                end
                S_DRAIN: begin
                    // Absorb the response to the final stimulus; PASS uses the final value.
                    SIG   <= sig_next;
                    PASS  <= (sig_next == EXP_SIG);
                    state <= S_DONE;
                    BUSY  <= 1'b0;
                    DONE  <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
